// File: rtl/cgra_lat_pkg.sv
// Shared definitions for the programmable-latency RF<->fabric bridge.
// Holds default sizes, latency-field width helper and the lane record type.
package cgra_lat_pkg;

  localparam int NUM_PORTS_DEF      = 4;
  localparam int WIDTH_DEF          = 32;
  localparam int MAX_PIPE_STAGE_DEF = 16;

  function automatic int lat_w(input int max_stage);
    return $clog2(max_stage + 1);
  endfunction

  // Latency field values beyond the deepest stage saturate to that stage.
  function automatic int clamp_lat(input int value, input int max_stage);
    return (value > max_stage) ? max_stage : value;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] data;
  } lane_t;

endpackage

// File: rtl/latency_pipe_v.sv
// One lane of programmable delay: shift stages of {valid,data}, a latency tap,
// global stall/flush and an any-valid flag over every stage.
module latency_pipe_v
  import cgra_lat_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int MAX_PIPE_STAGE = MAX_PIPE_STAGE_DEF,
  parameter int LW             = lat_w(MAX_PIPE_STAGE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             stall,
  input  logic [LW-1:0]    lat,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [MAX_PIPE_STAGE-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]          data_q [MAX_PIPE_STAGE];
  logic [WIDTH-1:0]          data_d [MAX_PIPE_STAGE];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      for (int k = 0; k < MAX_PIPE_STAGE; k++) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int k = 1; k < MAX_PIPE_STAGE; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < MAX_PIPE_STAGE; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Zero latency bypasses the stages entirely, so the tap ignores stall.
  always_comb begin
    out_valid = in_valid;
    out_data  = in_data;
    for (int k = 0; k < MAX_PIPE_STAGE; k++) begin
      if (lat == LW'(k + 1)) begin
        out_valid = valid_q[k];
        out_data  = data_q[k];
      end
    end
  end

  assign any_valid = |valid_q;

endmodule

// File: rtl/latency_io_ctl.sv
// Bidirectional per-port latency bridge between CGRA register file and fabric,
// with guarded latency reconfiguration and in-flight status.
module latency_io_ctl
  import cgra_lat_pkg::*;
#(
  parameter int NUM_PORTS      = NUM_PORTS_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int MAX_PIPE_STAGE = MAX_PIPE_STAGE_DEF,
  localparam int LW            = lat_w(MAX_PIPE_STAGE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      stall,
  input  logic                      cfg_we,
  input  logic [NUM_PORTS*LW-1:0]   cfg_lat_in,
  input  logic [NUM_PORTS*LW-1:0]   cfg_lat_out,
  output logic                      cfg_ack,
  output logic                      cfg_err,
  input  logic [NUM_PORTS*WIDTH-1:0] rf_rdata,
  input  logic [NUM_PORTS-1:0]      rf_rvalid,
  output logic [NUM_PORTS*WIDTH-1:0] cgra_in,
  output logic [NUM_PORTS-1:0]      cgra_in_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] cgra_out,
  input  logic [NUM_PORTS-1:0]      cgra_out_valid,
  output logic [NUM_PORTS*WIDTH-1:0] rf_wdata,
  output logic [NUM_PORTS-1:0]      rf_wvalid,
  output logic                      in_busy,
  output logic                      out_busy
);

  logic [LW-1:0]        lat_in_q  [NUM_PORTS];
  logic [LW-1:0]        lat_in_d  [NUM_PORTS];
  logic [LW-1:0]        lat_out_q [NUM_PORTS];
  logic [LW-1:0]        lat_out_d [NUM_PORTS];
  logic                 cfg_ack_q, cfg_ack_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [NUM_PORTS-1:0] in_any, out_any;
  logic                 cfg_accept;

  assign in_busy  = |in_any;
  assign out_busy = |out_any;

  // Latencies only change while nothing is in flight, so no entry ever sees two taps.
  assign cfg_accept = cfg_we && !clr && !in_busy && !out_busy;

  always_comb begin
    lat_in_d  = lat_in_q;
    lat_out_d = lat_out_q;
    cfg_ack_d = cfg_accept;
    cfg_err_d = cfg_we && !clr && (in_busy || out_busy);
    if (cfg_accept) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        lat_in_d[p]  = LW'(clamp_lat(int'(cfg_lat_in[p*LW +: LW]), MAX_PIPE_STAGE));
        lat_out_d[p] = LW'(clamp_lat(int'(cfg_lat_out[p*LW +: LW]), MAX_PIPE_STAGE));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        lat_in_q[p]  <= '0;
        lat_out_q[p] <= '0;
      end
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      lat_in_q  <= lat_in_d;
      lat_out_q <= lat_out_d;
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
    latency_pipe_v #(
      .WIDTH         (WIDTH),
      .MAX_PIPE_STAGE(MAX_PIPE_STAGE),
      .LW            (LW)
    ) u_in_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .stall    (stall),
      .lat      (lat_in_q[gi]),
      .in_valid (rf_rvalid[gi]),
      .in_data  (rf_rdata[gi*WIDTH +: WIDTH]),
      .out_valid(cgra_in_valid[gi]),
      .out_data (cgra_in[gi*WIDTH +: WIDTH]),
      .any_valid(in_any[gi])
    );

    latency_pipe_v #(
      .WIDTH         (WIDTH),
      .MAX_PIPE_STAGE(MAX_PIPE_STAGE),
      .LW            (LW)
    ) u_out_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .stall    (stall),
      .lat      (lat_out_q[gi]),
      .in_valid (cgra_out_valid[gi]),
      .in_data  (cgra_out[gi*WIDTH +: WIDTH]),
      .out_valid(rf_wvalid[gi]),
      .out_data (rf_wdata[gi*WIDTH +: WIDTH]),
      .any_valid(out_any[gi])
    );
  end

endmodule
